// File: rtl/alu_pkg.sv
// Shared ALU definitions for the round-robin ALU scheduler: control codes,
// legality check and request/response payload types.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        cout;
    logic        err;
  } alu_rsp_t;

  function automatic logic is_legal_ctl(input logic [3:0] ctl);
    return (ctl == ALU_AND) || (ctl == ALU_OR) || (ctl == ALU_ADD) || (ctl == ALU_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner
// and wraps; grant is suppressed when en is low, index/found are not.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NUM_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[wrap_idx(ptr, k)]) begin
        found                  = 1'b1;
        idx                    = wrap_idx(ptr, k);
        grant[wrap_idx(ptr, k)] = en;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external ALU between NUM_REQ requesters
// through an issue stage and a response stage. Optional ALU_CTL_CHECK_EN
// neutralises illegal control codes and flags them on rsp_err.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_ctl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [3:0]            alu_ctl,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_overflow,
  output logic                  rsp_cout,
  output logic                  rsp_err
);
  import alu_pkg::*;

  logic               issue_valid;
  logic               issue_err;
  alu_req_t           issue_q;
  logic [ID_W-1:0]    issue_id;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               win_found;
  logic               issue_adv;
  logic               can_issue;
  logic               accept;
  alu_req_t           win_req;
  alu_req_t           win_load;
  logic               win_err;
  alu_rsp_t           rsp_q;
  logic [ID_W-1:0]    rsp_id_q;

  assign issue_adv = issue_valid && (!rsp_valid || rsp_ready);
  assign can_issue = !issue_valid || issue_adv;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (can_issue),
    .grant (grant),
    .idx   (win_idx),
    .found (win_found)
  );

  assign req_ready = grant;
  assign accept    = win_found && can_issue;

  always_comb begin
    win_req.a   = req_a[32*win_idx +: 32];
    win_req.b   = req_b[32*win_idx +: 32];
    win_req.ctl = req_ctl[4*win_idx +: 4];
  end

`ifdef ALU_CTL_CHECK_EN
  // Illegal codes still occupy a slot but drive an inert AND 0,0 into the ALU.
  assign win_err  = !is_legal_ctl(win_req.ctl);
  assign win_load = win_err ? '0 : win_req;
`else
  assign win_err  = 1'b0;
  assign win_load = win_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_err   <= 1'b0;
      issue_q     <= '0;
      issue_id    <= '0;
      ptr         <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      issue_valid <= 1'b1;
      issue_err   <= win_err;
      issue_q     <= win_load;
      issue_id    <= win_idx;
      ptr         <= win_idx;
    end else if (issue_adv) begin
      issue_valid <= 1'b0;
    end
  end

  assign alu_a   = issue_valid ? issue_q.a   : 32'd0;
  assign alu_b   = issue_valid ? issue_q.b   : 32'd0;
  assign alu_ctl = issue_valid ? issue_q.ctl : ALU_AND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_id_q  <= '0;
    end else if (issue_adv) begin
      rsp_valid <= 1'b1;
      rsp_id_q  <= issue_id;
      if (issue_err)
        rsp_q <= '{result: 32'd0, zero: 1'b1, overflow: 1'b0, cout: 1'b0, err: 1'b1};
      else
        rsp_q <= '{result: alu_result, zero: alu_zero, overflow: alu_overflow,
                   cout: alu_cout, err: 1'b0};
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_q.result;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;
  assign rsp_cout     = rsp_q.cout;
  assign rsp_err      = rsp_q.err;

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 32-bit ALU between NUM_REQ requesters using round-robin arbitration.
- Two registered stages:
  - issue: winner's operands latched.
  - response: ALU outputs captured with requester ID.
- Valid/ready handshake on both the request side and the response side. Sits between the issuing units and the shared ALU; the ALU is external and connected through the alu_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ*32  flattened operand A, requester i at [32*i+:32].
- req_b  input  NUM_REQ*32  flattened operand B.
- req_ctl  input  NUM_REQ*4  flattened ALU control code.
- alu_a  output  32  operand A to the shared ALU.
- alu_b  output  32  operand B to the shared ALU.
- alu_ctl  output  4  control code to the shared ALU.
- alu_result  input  32  ALU result (combinational from alu_*).
- alu_zero, alu_overflow, alu_cout  input  1 each  ALU flags.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  ID_W  originating requester.
- rsp_result  output  32  captured result.
- rsp_zero, rsp_overflow, rsp_cout  output  1 each  captured flags.
- rsp_err  output  1  illegal control code flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - issue_valid=0 and rsp_valid=0.
  - All rsp_* outputs = 0.
  - alu_a=0, alu_b=0, alu_ctl=4'b0000.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation discards in-flight issue and response entries. No response is produced for them.
- Issue stage may accept (can_issue) when: !issue_valid, or the issue entry advances this cycle.
- Issue entry advances when: !rsp_valid, or rsp_ready.
- Arbitration, combinational:
  - Search req_valid starting at pointer+1, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready[win] = can_issue; all other req_ready bits = 0.
  - With no valid requests, req_ready = 0.
- On accept (req_valid[i] & req_ready[i]):
  - Latch a, b, ctl and id=i into the issue register; issue_valid=1.
  - Pointer = i.
  - Without an accept, the pointer holds.
- Requesters hold valid and a stable payload until accepted. The scheduler never drops an asserted request.
- alu_a/alu_b/alu_ctl are driven directly from the issue register while issue_valid=1; otherwise zero and 4'b0000.
- When the issue entry advances:
  - The response register captures alu_result and the three flags plus id; rsp_valid=1.
  - issue_valid clears unless a new accept occurs in the same cycle (back-to-back allowed).
- Response handshake:
  - rsp_valid & rsp_ready with no new capture → rsp_valid=0.
  - Simultaneous drain and capture → register reloads, rsp_valid stays 1.
- Backpressure:
  - rsp_valid=1 and rsp_ready=0 → issue entry stalls with alu_* held stable.
  - If issue_valid is also set, req_ready = 0 for all requesters.
- Latency and throughput:
  - Accept in cycle N → rsp_valid in cycle N+2.
  - Sustained throughput is 1 op/cycle with rsp_ready=1.
  - Maximum 2 ops in flight.
- Legal ctl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - All other codes are forwarded unchanged; the ALU returns result 0 for them.

Optional Feature:
- Macro: ALU_CTL_CHECK_EN.
- Defined:
  - An accepted request with an illegal ctl is still accepted and issued, with alu_ctl forced to 0000 and alu_a=alu_b=0.
  - Its response has rsp_err=1, rsp_result=0, rsp_zero=1, rsp_overflow=0, rsp_cout=0.
  - Legal ops give rsp_err=0.
- Undefined: no check is made; rsp_err is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - localparams ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - Function is_legal_ctl(ctl).
  - Typedef alu_req_t {a[31:0], b[31:0], ctl[3:0]}.
  - Typedef alu_rsp_t {result, zero, overflow, cout, err}.
- One sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, enable; outputs one-hot grant and encoded index.

Test Plan (bench models the ALU with the four legal ops):
- Single request: req0 ADD A=5, B=7 accepted at cycle N → rsp_valid at N+2 with rsp_id=0, result=12, zero=0.
- Overflow: req1 ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1. Then SUB 0 - 1 → 0xFFFFFFFF, cout=0.
- Fairness: all 4 valid continuously for 8 cycles, rsp_ready=1 → accepts in order 0,1,2,3,0,1,2,3, one per cycle, responses in the same order.
- Backpressure: hold rsp_ready=0 for 3 cycles with 2 ops in flight → req_ready all 0, alu_* stable, rsp unchanged. Release → both responses delivered in order, nothing lost or duplicated.
- Reset mid-op: assert rst_n=0 with issue and response full → all outputs 0 immediately. After release, pointer restarts at requester 0.
- ALU_CTL_CHECK_EN defined: req2 ctl=4'b1111, A=3, B=4 → rsp_err=1, result=0, zero=1. With the macro undefined → rsp_err=0 and result=0.
